// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared opcode encoding and flag bundle for the alu datapath.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Operation select encoding; all four codes are defined operations.
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  // Status flags in N, Z, C, V order (N is the MSB of the packed vector).
  typedef struct packed {
    logic N;
    logic Z;
    logic C;
    logic V;
  } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
// Module  : alu_addsub
// Brief   : WIDTH-bit adder with subtract control. Subtraction is a + ~b + 1,
//           so carry out means "no borrow" and overflow uses the inverted
//           operand's sign.
// Revision: 1.0 - initial release
// ============================================================================
module alu_addsub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  assign w_b_eff = i_sub ? ~i_b : i_b;

  // One carry chain serves both operations; i_sub doubles as the carry-in.
  assign w_full = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

  assign o_sum       = w_full[WIDTH-1:0];
  assign o_carry_out = w_full[WIDTH];

  // Signed overflow: both addends share a sign that the sum does not.
  assign o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_full[WIDTH-1] != i_a[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module  : alu
// Brief   : Registered WIDTH-bit ALU (add, sub, and, or) with N/Z/C/V flags.
//           One-cycle latency, one operation per cycle, async active-low clear.
// Revision: 1.0 - initial release
// ============================================================================
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       Sel,
  output logic [WIDTH-1:0] Result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  alu_op_e          w_op;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_result;
  alu_flags_t       w_flags;

  logic [WIDTH-1:0] r_result;
  alu_flags_t       r_flags;

  assign w_op = alu_op_e'(Sel);

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_a         (a),
    .i_b         (b),
    .i_sub       (w_op == ALU_SUB),
    .o_sum       (w_sum),
    .o_carry_out (w_cout),
    .o_overflow  (w_ovf)
  );

  // Opcode mux and flag derivation; logic ops bypass the adder and clear C/V.
  always_comb begin
    w_result  = w_sum;
    w_flags   = '0;
    w_flags.C = w_cout;
    w_flags.V = w_ovf;
    case (w_op)
      ALU_ADD, ALU_SUB: begin
        w_result  = w_sum;
        w_flags.C = w_cout;
        w_flags.V = w_ovf;
      end
      ALU_AND: begin
        w_result  = a & b;
        w_flags.C = 1'b0;
        w_flags.V = 1'b0;
      end
      ALU_OR: begin
        w_result  = a | b;
        w_flags.C = 1'b0;
        w_flags.V = 1'b0;
      end
      default: begin
        w_result  = w_sum;
      end
    endcase
    w_flags.N = w_result[WIDTH-1];
    w_flags.Z = (w_result == '0);
  end

  // Output register bank; reset clears all flags (Z too) to mean "no valid op".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_result <= w_result;
      r_flags  <= w_flags;
    end
  end

  assign Result = r_result;
  assign N      = r_flags.N;
  assign Z      = r_flags.Z;
  assign C      = r_flags.C;
  assign V      = r_flags.V;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu
// Brief   : Self-checking bench for alu: directed cases, randomized vectors
//           against an integer-arithmetic reference model, mid-cycle input
//           wiggles and asynchronous reset pulses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu;

  localparam int WIDTH = 4;
  localparam int M     = 2 ** WIDTH;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic [WIDTH-1:0] result;
  logic             n_f;
  logic             z_f;
  logic             c_f;
  logic             v_f;

  int n_vec;
  int n_err;

  alu #(
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .Sel    (sel),
    .Result (result),
    .N      (n_f),
    .Z      (z_f),
    .C      (c_f),
    .V      (v_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  // Reference: returns {Result, N, Z, C, V} from plain integer arithmetic.
  function automatic logic [WIDTH+3:0] model(input int x, input int y, input int op);
    int r, s;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin
        r = (x + y) % M;
        c = (x + y) >= M;
        s = sx(x) + sx(y);
        v = (s < -(M / 2)) || (s > M / 2 - 1);
      end
      1: begin
        r = (x - y + M) % M;
        c = (x >= y);
        s = sx(x) - sx(y);
        v = (s < -(M / 2)) || (s > M / 2 - 1);
      end
      2: r = x & y;
      default: r = x | y;
    endcase
    return {r[WIDTH-1:0], (r >= M / 2), (r == 0), c, v};
  endfunction

  function automatic logic [31:0] observed();
    return 32'({result, n_f, z_f, c_f, v_f});
  endfunction

  // Drive one operation one time unit after an edge, then check it after the next edge.
  task automatic apply(input string tag, input int x, input int y, input int op);
    a   = x[WIDTH-1:0];
    b   = y[WIDTH-1:0];
    sel = op[1:0];
    @(posedge clk);
    #1;
    check(tag, observed(), 32'(model(x, y, op)));
  endtask

  logic [WIDTH+3:0] exp_prev;
  int               ra, rb, rop;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    a     = 4'hA;
    b     = 4'h3;
    sel   = 2'd1;

    // Reset held with arbitrary inputs across several edges.
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", observed(), 32'd0);
    a = 4'hF; b = 4'hF; sel = 2'd0;
    @(posedge clk);
    #1;
    check("reset_hold_edge", observed(), 32'd0);

    // Release, present 4+5: nothing changes until the next edge.
    rst_n = 1'b1;
    a = 4'd4; b = 4'd5; sel = 2'd0;
    #3;
    check("post_reset_wait", observed(), 32'd0);
    @(posedge clk);
    #1;
    check("add_4_5", observed(), 32'({4'd9, 1'b1, 1'b0, 1'b0, 1'b1}));

    // Directed cases from the operation table.
    apply("add_15_15", 15, 15, 0);
    check("add_15_15_const", observed(), 32'({4'd14, 1'b1, 1'b0, 1'b1, 1'b0}));
    apply("sub_0_10", 0, 10, 1);
    check("sub_0_10_const", observed(), 32'({4'd6, 1'b0, 1'b0, 1'b0, 1'b0}));
    apply("sub_15_9", 15, 9, 1);
    check("sub_15_9_const", observed(), 32'({4'd6, 1'b0, 1'b0, 1'b1, 1'b0}));
    apply("sub_7_7", 7, 7, 1);
    check("sub_7_7_const", observed(), 32'({4'd0, 1'b0, 1'b1, 1'b1, 1'b0}));
    apply("sub_8_1", 8, 1, 1);
    apply("and_15_0", 15, 0, 2);
    check("and_15_0_const", observed(), 32'({4'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    apply("and_12_4", 12, 4, 2);
    check("and_12_4_const", observed(), 32'({4'd4, 1'b0, 1'b0, 1'b0, 1'b0}));
    apply("or_10_5", 10, 5, 3);
    check("or_10_5_const", observed(), 32'({4'd15, 1'b1, 1'b0, 1'b0, 1'b0}));
    apply("or_0_0", 0, 0, 3);
    check("or_0_0_const", observed(), 32'({4'd0, 1'b0, 1'b1, 1'b0, 1'b0}));

    // Randomized back-to-back operations with mid-cycle wiggles and reset pulses.
    exp_prev = model(0, 0, 3);
    for (int i = 0; i < 300; i++) begin
      ra  = int'($urandom_range(0, M - 1));
      rb  = int'($urandom_range(0, M - 1));
      rop = int'($urandom_range(0, 3));
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      sel = 2'($urandom);
      #2;
      check("hold_between_edges", observed(), 32'(exp_prev));
      a   = ra[WIDTH-1:0];
      b   = rb[WIDTH-1:0];
      sel = rop[1:0];
      if (i % 37 == 5) begin
        #1 rst_n = 1'b0;
        #1 check("async_clear", observed(), 32'd0);
        #1 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
      exp_prev = model(ra, rb, rop);
      check("random", observed(), 32'(exp_prev));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound in case anything stalls the stimulus.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time bound");
    $fatal(1);
  end

endmodule
`default_nettype wire
